// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte scheduler for a shared UART transmitter with watchdog; UART_ARB_LOCK_EN makes grants sticky.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_lock,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_start_clear,
    input  logic                 i_tx_busy,
    output logic                 o_timeout
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;

    state_t             state;
    logic [PW-1:0]      ptr, win, k;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] win_oh;
    logic               accept, tmo;

    // scan from farthest to nearest so the first valid after ptr is written last
    always_comb begin
        win = ptr;
        k = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = PW'((int'(ptr) + i) % NUM_REQ);
            if (i_req_valid[k]) win = k;
        end
`ifdef UART_ARB_LOCK_EN
        if (i_lock[ptr] && i_req_valid[ptr]) win = ptr;
`endif
    end

`ifndef UART_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^i_lock;
`endif

    assign win_oh      = NUM_REQ'(1) << win;
    assign accept      = !wb_rst_i && state == IDLE && !i_tx_busy && |i_req_valid;
    assign o_req_ready = accept ? win_oh : '0;
    assign tmo         = TIMEOUT_CYCLES > 0 && int'(cnt) == TIMEOUT_CYCLES - 1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_grant    <= '0;
            o_timeout  <= 1'b0;
            ptr        <= PW'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            o_timeout <= 1'b0;
            if (state != IDLE && int'(cnt) < TIMEOUT_CYCLES) cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_tx_data  <= i_req_data[{win, 3'b000} +: 8];
                        o_grant    <= win_oh;
                        ptr        <= win;
                        o_tx_start <= 1'b1;
                        cnt        <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (i_tx_start_clear) begin
                        o_tx_start <= 1'b0;
                        state      <= DRAIN;
                    end else if (tmo) begin
                        o_timeout  <= 1'b1;
                        o_tx_start <= 1'b0;
                        o_grant    <= '0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!i_tx_busy) begin
                        o_grant <= '0;
                        state   <= IDLE;
                    end else if (tmo) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; stimulus queues expected (grant, byte), monitor checks each start rise.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   lock = '0;
    logic [8*N-1:0] req_data = '0;
    logic           clr = 1'b0, busy_m = 1'b0, busy_f = 1'b0;
    logic [N-1:0]   ready, grant;
    logic [7:0]     tx_data;
    logic           tx_start, timeout;
    logic           prev_start = 1'b0;
    bit             tx_auto = 1'b1;
    int             clr_dly = 3, busy_len = 10;
    int             total = 0, bad = 0;
    int             exp_idx[$];
    logic [7:0]     exp_dat[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .i_req_valid(req_valid),
        .i_req_data(req_data),
        .i_lock(lock),
        .o_req_ready(ready),
        .o_grant(grant),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_start_clear(clr),
        .i_tx_busy(busy_m | busy_f),
        .o_timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_b(input int idx, input logic [7:0] d);
        exp_idx.push_back(idx);
        exp_dat.push_back(d);
    endtask

    task automatic send(input int idx, input logic [7:0] d);
        int n = 0;
        req_data[8*idx +: 8] = d;
        req_valid[idx] = 1'b1;
        #1;
        while (!ready[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready[idx]) begin
            total++;
            bad++;
            $display("FAIL accept_wait req%0d: got no ready want ready", idx);
        end else @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((grant != 0 || tx_start) && n < 200);
        chk("idle_grant", grant, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // transmitter model: consumes start after clr_dly cycles, then busy for busy_len cycles
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && tx_auto && !rst) begin
                repeat (clr_dly - 1) @(negedge clk);
                clr = 1'b1;
                busy_m = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                repeat (busy_len - 1) @(negedge clk);
                busy_m = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !prev_start) begin
                if (exp_idx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got grant %0h data %0h want none", grant, tx_data);
                end else begin
                    chk("sb_grant", grant, 32'(1) << exp_idx.pop_front());
                    chk("sb_tx_data", tx_data, exp_dat.pop_front());
                end
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n, m;
        logic seen;
        req_valid = '1;
        req_data = 32'h44332211;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_grant", grant, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        #1;
        chk("first_ready", ready, 4'b0001);
        chk("first_start", tx_start, 0);
        expect_b(0, 8'h11);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        req_data[23:16] = 8'hA5;
        req_valid[2] = 1'b1;
        #1;
        chk("t2_ready", ready, 4'b0100);
        expect_b(2, 8'hA5);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("t2_ready_drop", ready, 0);
        n = 0;
        while (tx_start && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_start_cycles", n, 3);
        chk("t2_grant_held", grant, 4'b0100);
        m = n;
        while (grant != 0 && m < 60) begin
            m++;
            @(negedge clk);
        end
        chk("t2_grant_cycles", m, 13);

        do_reset();
        expect_b(0, 8'h00); expect_b(1, 8'h10); expect_b(2, 8'h20);
        expect_b(3, 8'h30); expect_b(0, 8'h01); expect_b(1, 8'h11);
        fork
            begin send(0, 8'h00); send(0, 8'h01); end
            begin send(1, 8'h10); send(1, 8'h11); end
            send(2, 8'h20);
            send(3, 8'h30);
        join
        wait_idle();

        busy_f = 1'b1;
        req_data[15:8] = 8'h4B;
        req_valid[1] = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | (ready != 0);
        end
        chk("t4_blocked", seen, 0);
        busy_f = 1'b0;
        #1;
        chk("t4_ready", ready, 4'b0010);
        expect_b(1, 8'h4B);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        tx_auto = 1'b0;
        expect_b(3, 8'h3C);
        expect_b(0, 8'h0C);
        fork
            send(3, 8'h3C);
            send(0, 8'h0C);
            begin
                n = 0;
                while (!tx_start && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                m = 0;
                while (!timeout && m < 40) begin
                    @(negedge clk);
                    m++;
                end
                chk("t5_timeout_cycles", m, 16);
                chk("t5_start_fall", tx_start, 0);
                chk("t5_grant_drop", grant, 0);
                tx_auto = 1'b1;
                @(negedge clk);
                chk("t5_pulse_width", timeout, 0);
            end
        join
        wait_idle();

        clr_dly = 15;
        busy_len = 1;
        expect_b(1, 8'h5B);
        fork
            send(1, 8'h5B);
            begin
                seen = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    seen = seen | timeout;
                end
            end
        join
        chk("t5b_no_timeout", seen, 0);
        wait_idle();
        clr_dly = 3;
        busy_len = 10;

        do_reset();
        lock[0] = 1'b1;
`ifdef UART_ARB_LOCK_EN
        expect_b(0, 8'h60); expect_b(0, 8'h61); expect_b(0, 8'h62);
        expect_b(1, 8'h70); expect_b(1, 8'h71);
`else
        expect_b(0, 8'h60); expect_b(1, 8'h70); expect_b(0, 8'h61);
        expect_b(1, 8'h71); expect_b(0, 8'h62);
`endif
        fork
            begin send(0, 8'h60); send(0, 8'h61); send(0, 8'h62); lock[0] = 1'b0; end
            begin send(1, 8'h70); send(1, 8'h71); end
        join
        wait_idle();

        chk("queue_empty", exp_idx.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
